mult_seq_ctrl: RTL and testbench
================================

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameter OP_ADD, default 8'b0000_0101, ALU opcode for A+B.
REQ-002 Parameter OP_SUB, default 8'b0000_1001, ALU opcode for A-B.
REQ-003 Parameter Z_BIT, default 3, index of the zero flag in flags.
REQ-004 Parameter SCRATCH, default 4'd15, register used as loop counter.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  request: dst <= src_a * src_b (low 16 bits).
REQ-008 abort  in  1  cancel operation in progress.
REQ-009 src_a, src_b, dst  in  4 each  register indices, sampled only on an accepted start.
REQ-010 flags  in  5  datapath flag register output.
REQ-011 alu_op  out  8  ALU opcode.
REQ-012 muxes  out  8  [7:4] A-operand register select, [3:0] B-operand register select.
REQ-013 regs_en  out  16  one-hot register write enable, or all zero.
REQ-014 imm  out  16  immediate value; imm_sel out 1 selects imm onto B.
REQ-015 flags_en  out  1  flag register write enable.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse on successful completion.
REQ-018 err  out  1  one-cycle pulse on a rejected start.

Function
REQ-019 States: IDLE, CLR, LDCNT, CHK0, ADD, DEC, CHK, DONE; one transition per clock.
REQ-020 IDLE: start=1 with legal indices latches indices, next CLR; illegal indices pulse err next cycle, stay IDLE.
REQ-021 Illegal: dst equals src_a, src_b or SCRATCH, or src_a equals SCRATCH; src_a==src_b and src_b==SCRATCH are legal.
REQ-022 CLR: OP_SUB, A=B=src_a, imm_sel=0, regs_en[dst]=1, flags_en=1 (dst <= 0).
REQ-023 LDCNT: OP_ADD, A=src_b, imm_sel=1, imm=0, regs_en[SCRATCH]=1, flags_en=1.
REQ-024 CHK0: regs_en=0, flags_en=0; flags[Z_BIT]=1 -> DONE, else ADD.
REQ-025 ADD: OP_ADD, A=dst, B=src_a, imm_sel=0, regs_en[dst]=1, flags_en=0.
REQ-026 DEC: OP_SUB, A=SCRATCH, imm_sel=1, imm=1, regs_en[SCRATCH]=1, flags_en=1.
REQ-027 CHK: regs_en=0, flags_en=0; flags[Z_BIT]=1 -> DONE, else ADD.
REQ-028 DONE: done=1, regs_en=0, next IDLE.
REQ-029 Latency from start edge to done: 4 + 3*src_b_value cycles; src_b=0 gives 4.
REQ-030 Product wraps modulo 2^16; carry/overflow flags ignored.
REQ-031 start while busy is ignored; no queuing.
REQ-032 abort while busy: next state IDLE, regs_en=0 that cycle onward, no done; dst/SCRATCH contents undefined.
REQ-033 abort and start together in IDLE: abort has priority, start ignored.
REQ-034 In IDLE, DONE, CHK0, CHK: regs_en=0, alu_op=OP_ADD, muxes=0, imm=0, imm_sel=0.

Reset
REQ-035 reset=1 forces IDLE immediately, asynchronously, including mid-operation.
REQ-036 Reset values: busy=0, done=0, err=0, regs_en=0, flags_en=0, alu_op=OP_ADD, muxes=0, imm=0, imm_sel=0, latched indices=0.

Structure
REQ-037 Opcode constants, state enumeration and flag bit indices reside in the shared CPU package.
REQ-038 One sub-module, reg_onehot_dec (4-bit index + enable -> 16-bit one-hot), generates regs_en.
REQ-039 Outputs are combinational decodes of the registered state and latched indices; no combinational path from flags to any output.

Verification
REQ-040 Datapath preloaded r1=3, r2=5; start src_a=1, src_b=2, dst=3 -> done after 19 cycles, r3=15, r1/r2 unchanged.
REQ-041 r2=0; start src_a=1, src_b=2, dst=3 -> done after 4 cycles, r3=0.
REQ-042 start dst=1, src_a=1 -> err pulse 1 cycle, busy stays 0, no register written.
REQ-043 r1=7, r2=10; abort on 6th busy cycle -> IDLE next cycle, no done, regs_en=0 thereafter.
REQ-044 start asserted during operation -> ignored; single done; result of first request only.
REQ-045 reset asserted mid-ADD, asynchronous to clk -> busy=0 and regs_en=0 before next clock edge.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared CPU package for the multiply sequencer.
// Contents: ALU opcode constants, flag bit indices, the sequencer state
// enumeration and the start-legality check used when a request is accepted.
package mult_seq_pkg;

  localparam logic [7:0] OP_ADD_DEFAULT = 8'b0000_0101;
  localparam logic [7:0] OP_SUB_DEFAULT = 8'b0000_1001;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_S = 4;

  localparam logic [3:0] SCRATCH_DEFAULT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LDCNT,
    S_CHK0,
    S_ADD,
    S_DEC,
    S_CHK,
    S_DONE
  } state_t;

  // The destination must not alias either source or the loop counter, and
  // the multiplicand must not be the loop counter (it is re-read every pass).
  // src_b may be the counter: it is only read once, before counting starts.
  function automatic logic idx_illegal(input logic [3:0] src_a,
                                       input logic [3:0] src_b,
                                       input logic [3:0] dst,
                                       input logic [3:0] scratch);
    return (dst == src_a) || (dst == src_b) || (dst == scratch) ||
           (src_a == scratch);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_dec.sv
// reg_onehot_dec: register write-enable decoder.
// Ports:
//   i_idx    [3:0]  register index
//   i_en            write request
//   o_onehot [15:0] one-hot enable for i_idx when i_en, otherwise all zero
module reg_onehot_dec (
  input  logic [3:0]  i_idx,
  input  logic        i_en,
  output logic [15:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: shift-free multiply sequencer. Drives an external
// register-file/ALU datapath to compute dst <= src_a * src_b (mod 2^16) by
// repeated addition, using register SCRATCH as a down-counter.
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | waiting for start; indices checked here
// CLR    | dst <= src_a - src_a (clears dst)
// LDCNT  | SCRATCH <= src_b + 0, sets Z if multiplier is zero
// CHK0   | Z set -> DONE, else first ADD
// ADD    | dst <= dst + src_a
// DEC    | SCRATCH <= SCRATCH - 1, updates Z
// CHK    | Z set -> DONE, else ADD again
// DONE   | one-cycle completion pulse
//
// Ports:
//   i_clk, i_reset                 clock, async active-high reset
//   i_start, i_abort               request / cancel
//   i_src_a, i_src_b, i_dst [3:0]  register indices (latched on accept)
//   i_flags [4:0]                  datapath flag register
//   o_alu_op [7:0]                 ALU opcode
//   o_muxes [7:0]                  {A select, B select}
//   o_regs_en [15:0]               one-hot register write enable
//   o_imm [15:0], o_imm_sel        immediate operand and its B-mux select
//   o_flags_en                     flag register write enable
//   o_busy, o_done, o_err          status
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter logic [7:0]  OP_ADD  = OP_ADD_DEFAULT,
  parameter logic [7:0]  OP_SUB  = OP_SUB_DEFAULT,
  parameter int unsigned Z_BIT   = FLAG_Z,
  parameter logic [3:0]  SCRATCH = SCRATCH_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [3:0]  i_src_a,
  input  logic [3:0]  i_src_b,
  input  logic [3:0]  i_dst,
  input  logic [4:0]  i_flags,
  output logic [7:0]  o_alu_op,
  output logic [7:0]  o_muxes,
  output logic [15:0] o_regs_en,
  output logic [15:0] o_imm,
  output logic        o_imm_sel,
  output logic        o_flags_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_src_a;
  logic [3:0] r_src_b;
  logic [3:0] r_dst;
  logic       r_err;

  logic       w_illegal;
  logic       w_req;
  logic       w_accept;
  logic [3:0] w_a_sel;
  logic [3:0] w_b_sel;
  logic [3:0] w_wr_idx;
  logic       w_wr_en;
  logic       w_flags_en;

  assign w_illegal = idx_illegal(i_src_a, i_src_b, i_dst, SCRATCH);
  // abort outranks start in IDLE
  assign w_req     = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_accept  = w_req && !w_illegal;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_req && w_illegal;
      if (w_accept) begin
        r_src_a <= i_src_a;
        r_src_b <= i_src_b;
        r_dst   <= i_dst;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_accept) w_next = S_CLR;
      S_CLR:        w_next = S_LDCNT;
      S_LDCNT:      w_next = S_CHK0;
      S_CHK0, S_CHK: w_next = i_flags[Z_BIT] ? S_DONE : S_ADD;
      S_ADD:        w_next = S_DEC;
      S_DEC:        w_next = S_CHK;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end

  always_comb begin
    o_alu_op   = OP_ADD;
    w_a_sel    = '0;
    w_b_sel    = '0;
    o_imm      = '0;
    o_imm_sel  = 1'b0;
    w_wr_idx   = r_dst;
    w_wr_en    = 1'b0;
    w_flags_en = 1'b0;
    case (r_state)
      S_CLR: begin
        o_alu_op   = OP_SUB;
        w_a_sel    = r_src_a;
        w_b_sel    = r_src_a;
        w_wr_en    = 1'b1;
        w_flags_en = 1'b1;
      end
      S_LDCNT: begin
        w_a_sel    = r_src_b;
        o_imm_sel  = 1'b1;
        w_wr_idx   = SCRATCH;
        w_wr_en    = 1'b1;
        w_flags_en = 1'b1;
      end
      S_ADD: begin
        w_a_sel    = r_dst;
        w_b_sel    = r_src_a;
        w_wr_en    = 1'b1;
      end
      S_DEC: begin
        o_alu_op   = OP_SUB;
        w_a_sel    = SCRATCH;
        o_imm_sel  = 1'b1;
        o_imm      = 16'd1;
        w_wr_idx   = SCRATCH;
        w_wr_en    = 1'b1;
        w_flags_en = 1'b1;
      end
      default: ;
    endcase
  end

  // An abort must stop datapath writes in the very cycle it is raised.
  reg_onehot_dec u_dec (
    .i_idx    (w_wr_idx),
    .i_en     (w_wr_en && !i_abort),
    .o_onehot (o_regs_en)
  );

  assign o_muxes    = {w_a_sel, w_b_sel};
  assign o_flags_en = w_flags_en && !i_abort;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE) && !i_abort;
  assign o_err      = r_err;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl. A small register-file/ALU environment reacts
// to the controller outputs; results are checked against plain arithmetic
// (product, latency 4 + 3*multiplier, untouched registers).
module tb_mult_seq_ctrl;

  localparam logic [7:0] OP_ADD  = 8'b0000_0101;
  localparam logic [7:0] OP_SUB  = 8'b0000_1001;
  localparam int         Z_BIT   = 3;
  localparam logic [3:0] SCRATCH = 4'd15;
  localparam int         BUDGET  = 200;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [3:0]  src_a, src_b, dst;
  logic [4:0]  flags;
  logic [7:0]  alu_op, muxes;
  logic [15:0] regs_en, imm;
  logic        imm_sel, flags_en, busy, done, err;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] dp_r [16];
  logic [4:0]  dp_flags;
  logic [15:0] pl_vals [16];
  logic        pl_go;
  logic [15:0] opnd_a, opnd_b, alu_res;

  always #5 clk = ~clk;

  mult_seq_ctrl dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_abort    (abort),
    .i_src_a    (src_a),
    .i_src_b    (src_b),
    .i_dst      (dst),
    .i_flags    (flags),
    .o_alu_op   (alu_op),
    .o_muxes    (muxes),
    .o_regs_en  (regs_en),
    .o_imm      (imm),
    .o_imm_sel  (imm_sel),
    .o_flags_en (flags_en),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  // Datapath environment: register file, ALU and zero flag.
  assign flags = dp_flags;

  always_comb begin
    opnd_a  = dp_r[muxes[7:4]];
    opnd_b  = imm_sel ? imm : dp_r[muxes[3:0]];
    alu_res = (alu_op == OP_SUB) ? opnd_a - opnd_b : opnd_a + opnd_b;
  end

  always @(posedge clk) begin
    if (pl_go) begin
      for (int i = 0; i < 16; i++) dp_r[i] <= pl_vals[i];
      dp_flags <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (regs_en[i]) dp_r[i] <= alu_res;
      if (flags_en) dp_flags[Z_BIT] <= (alu_res == 16'd0);
    end
  end

  function automatic bit tb_illegal(input logic [3:0] a, input logic [3:0] b,
                                    input logic [3:0] d);
    return (d == a) || (d == b) || (d == SCRATCH) || (a == SCRATCH);
  endfunction

  task automatic randomize_regs();
    for (int i = 0; i < 16; i++) pl_vals[i] = 16'($urandom);
  endtask

  task automatic apply_preload();
    @(negedge clk); pl_go = 1'b1;
    @(negedge clk); pl_go = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input bit noise, input string tag);
    logic [15:0] snap [16];
    logic [31:0] full;
    logic [15:0] exp_prod;
    int exp_lat, cnt, diffs;
    bit seen, busy_ok;
    @(negedge clk);
    for (int i = 0; i < 16; i++) snap[i] = dp_r[i];
    full     = 32'(snap[a]) * 32'(snap[b]);
    exp_prod = full[15:0];
    exp_lat  = 4 + 3 * int'(snap[b]);
    src_a = a; src_b = b; dst = d; start = 1'b1;
    cnt = 0; seen = 0; busy_ok = 1;
    while (!seen && cnt < BUDGET) begin
      @(posedge clk); cnt++;
      @(negedge clk);
      if (noise && cnt < 6) begin
        src_a = 4'd5; src_b = 4'd6; dst = 4'd4; start = 1'b1;
      end else start = 1'b0;
      if (done) seen = 1;
      else if (!busy) busy_ok = 0;
    end
    start = 1'b0;
    n_vec++;
    if (!seen || cnt != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d (done seen %0d) expected %0d", tag, cnt, seen, exp_lat);
    end
    n_vec++;
    if (!busy_ok) begin
      n_err++;
      $display("FAIL %s busy_during_op: busy dropped, expected 1 until done", tag);
    end
    n_vec++;
    if (dp_r[d] !== exp_prod) begin
      n_err++;
      $display("FAIL %s product: got %0d expected %0d", tag, dp_r[d], exp_prod);
    end
    diffs = 0;
    for (int i = 0; i < 16; i++)
      if (i != int'(d) && i != int'(SCRATCH) && dp_r[i] !== snap[i]) diffs++;
    n_vec++;
    if (diffs != 0) begin
      n_err++;
      $display("FAIL %s other_regs: %0d changed, expected 0", tag, diffs);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: done=%b busy=%b expected 0 0", tag, done, busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if ({busy, done, err, flags_en} !== 4'b0000) begin
      n_err++;
      $display("FAIL %s status: got %b expected 0000", tag, {busy, done, err, flags_en});
    end
    n_vec++;
    if (regs_en !== 16'h0000) begin
      n_err++;
      $display("FAIL %s regs_en: got %h expected 0000", tag, regs_en);
    end
    n_vec++;
    if ({alu_op, muxes, imm, imm_sel} !== {OP_ADD, 8'h00, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL %s datapath_ctl: alu_op=%h muxes=%h imm=%h imm_sel=%b expected %h 00 0000 0",
               tag, alu_op, muxes, imm, imm_sel, OP_ADD);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_a = '0; src_b = '0; dst = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    randomize_regs();
    apply_preload();
  endtask

  task automatic test_directed();
    randomize_regs(); pl_vals[1] = 16'd3; pl_vals[2] = 16'd5;
    apply_preload();
    do_op(4'd1, 4'd2, 4'd3, 1'b0, "mul_3x5");
    randomize_regs(); pl_vals[1] = 16'd3; pl_vals[2] = 16'd0;
    apply_preload();
    do_op(4'd1, 4'd2, 4'd3, 1'b0, "mul_by_0");
  endtask

  task automatic test_random();
    logic [3:0] a, b, d;
    for (int t = 0; t < 12; t++) begin
      do begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        d = 4'($urandom_range(0, 15));
      end while (tb_illegal(a, b, d));
      randomize_regs();
      pl_vals[b] = 16'($urandom_range(0, 12));
      apply_preload();
      do_op(a, b, d, 1'b0, "random");
    end
  endtask

  task automatic test_illegal();
    logic [15:0] snap [16];
    logic [3:0] a, b, d;
    bit ill;
    int diffs;
    randomize_regs();
    apply_preload();
    @(negedge clk);
    for (int i = 0; i < 16; i++) snap[i] = dp_r[i];
    src_a = 4'd1; src_b = 4'd2; dst = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_vec++;
    if (err !== 1'b1 || busy !== 1'b0 || regs_en !== 16'h0) begin
      n_err++;
      $display("FAIL err_pulse: err=%b busy=%b regs_en=%h expected 1 0 0000", err, busy, regs_en);
    end
    @(negedge clk);
    n_vec++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL err_width: err=%b busy=%b expected 0 0", err, busy);
    end
    diffs = 0;
    for (int i = 0; i < 16; i++) if (dp_r[i] !== snap[i]) diffs++;
    n_vec++;
    if (diffs != 0) begin
      n_err++;
      $display("FAIL err_no_write: %0d registers changed, expected 0", diffs);
    end
    for (int t = 0; t < 16; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      b = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      d = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      ill = tb_illegal(a, b, d);
      src_a = a; src_b = b; dst = d; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n_vec++;
      if (err !== ill || busy !== !ill) begin
        n_err++;
        $display("FAIL legality a=%0d b=%0d d=%0d: err=%b busy=%b expected %b %b",
                 a, b, d, err, busy, ill, !ill);
      end
      if (!ill) begin
        abort = 1'b1; @(negedge clk); abort = 1'b0;
      end
      @(negedge clk);
    end
    src_a = 4'd1; src_b = 4'd2; dst = 4'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL abort_priority: busy=%b err=%b expected 0 0", busy, err);
    end
  endtask

  task automatic test_abort();
    int k;
    bit bad;
    for (int t = 0; t < 5; t++) begin
      k = (t == 0) ? 6 : (t == 1) ? 4 : (t == 2) ? 5 : $urandom_range(1, 12);
      randomize_regs(); pl_vals[1] = 16'd7; pl_vals[2] = 16'd10;
      apply_preload();
      src_a = 4'd1; src_b = 4'd2; dst = 4'd3; start = 1'b1;
      for (int c = 0; c < k; c++) begin
        @(posedge clk); @(negedge clk); start = 1'b0;
      end
      abort = 1'b1;
      #1;
      n_vec++;
      if (regs_en !== 16'h0 || flags_en !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL abort_gate cycle %0d: regs_en=%h flags_en=%b done=%b expected 0000 0 0",
                 k, regs_en, flags_en, done);
      end
      @(negedge clk); abort = 1'b0;
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_idle cycle %0d: busy=%b expected 0", k, busy);
      end
      bad = 0;
      repeat (40) begin
        @(negedge clk);
        if (done !== 1'b0 || regs_en !== 16'h0 || busy !== 1'b0) bad = 1;
      end
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL abort_quiet cycle %0d: activity seen after abort, expected none", k);
      end
    end
  endtask

  task automatic test_reset_mid();
    randomize_regs(); pl_vals[1] = 16'd7; pl_vals[2] = 16'd10;
    apply_preload();
    src_a = 4'd1; src_b = 4'd2; dst = 4'd3; start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk); start = 1'b0;
    end
    n_vec++;
    if (regs_en !== 16'h0008 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL add_wen: regs_en=%h busy=%b expected 0008 1", regs_en, busy);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || regs_en !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b regs_en=%h expected 0 0000", busy, regs_en);
    end
    @(negedge clk);
    check_reset_outputs("reset_mid");
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    randomize_regs();
    pl_vals[1] = 16'd3; pl_vals[2] = 16'd5; pl_vals[5] = 16'd6;
    pl_vals[7] = 16'd2; pl_vals[8] = 16'd4;
    apply_preload();
    do_op(4'd1, 4'd2, 4'd3, 1'b1, "start_while_busy");
    do_op(4'd7, 4'd8, 4'd9, 1'b0, "back_to_back");
  endtask

  initial begin
    pl_go = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
